// File: rtl/bcd_down_cnt_s.sv
// rtl/bcd_down_cnt_s.sv - synchronous multi-digit BCD down-counter with preset, wrap and terminal count
module bcd_down_cnt_s #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b0
) (
    input  logic                  CK,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic                  En,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Zero,
    output logic                  Tc
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] dec_val;
    logic                borrow;

    // Borrow enters digit 0 and ripples upward through zero digits in one cycle.
    always_comb begin
        load_val = '0;
        dec_val  = '0;
        borrow   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_val[4*i +: 4] = (D[4*i +: 4] > 4'd9) ? 4'd9 : D[4*i +: 4];
            if (borrow) begin
                if (Q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = Q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = Q[4*i +: 4];
            end
        end
    end

    assign Zero = (Q == '0);

    always_ff @(posedge CK) begin
        if (Clear) begin
            Q  <= '0;
            Tc <= 1'b0;
        end else if (Load) begin
            Q  <= load_val;
            Tc <= 1'b0;
        end else if (En) begin
            if (Zero) begin
                Q  <= WRAP ? ALL_NINES : Q;
                Tc <= 1'b0;
            end else begin
                Q  <= dec_val;
                Tc <= (dec_val == '0);
            end
        end else begin
            Tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_down_cnt_s.sv
// tb/tb_bcd_down_cnt_s.sv - self-checking bench for bcd_down_cnt_s
module tb_bcd_down_cnt_s;

    logic        ck = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic [11:0] d3 = '0;

    logic [7:0]  qa, qb;
    logic [11:0] qc;
    logic        za, zb, zc, tca, tcb, tcc;

    always #5 ck = ~ck;

    bcd_down_cnt_s #(.DIGITS(2), .WRAP(1'b0)) dut_a (
        .CK(ck), .Clear(clear), .Load(load), .En(en), .D(d3[7:0]),
        .Q(qa), .Zero(za), .Tc(tca));

    bcd_down_cnt_s #(.DIGITS(2), .WRAP(1'b1)) dut_b (
        .CK(ck), .Clear(clear), .Load(load), .En(en), .D(d3[7:0]),
        .Q(qb), .Zero(zb), .Tc(tcb));

    bcd_down_cnt_s #(.DIGITS(3), .WRAP(1'b0)) dut_c (
        .CK(ck), .Clear(clear), .Load(load), .En(en), .D(d3),
        .Q(qc), .Zero(zc), .Tc(tcc));

    typedef struct {
        logic       clr;
        logic       ld;
        logic       en;
        logic [7:0] d;
        logic [7:0] qa;
        logic       tca;
        logic [7:0] qb;
        logic       tcb;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   ma, mb, mc;
    bit   ta, tb, tcm;

    function automatic int bcd_val(logic [11:0] d, int n);
        int v = 0;
        for (int i = n - 1; i >= 0; i--) begin
            int dig = int'(d[4*i +: 4]);
            if (dig > 9) dig = 9;
            v = v * 10 + dig;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_bcd(int v, int n);
        logic [11:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int nxt_m(int m, int n, bit w, logic c, logic l, logic e, logic [11:0] d);
        if (c) return 0;
        if (l) return bcd_val(d, n);
        if (e) begin
            if (m != 0) return m - 1;
            return w ? (10 ** n) - 1 : 0;
        end
        return m;
    endfunction

    function automatic bit nxt_t(int m, logic c, logic l, logic e);
        if (c || l) return 1'b0;
        return e && (m == 1);
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (vector %0d)", name, act, exp, n_vec);
        end
    endtask

    task automatic step(input logic c, input logic l, input logic e, input logic [11:0] d);
        bit na, nb, nc;
        clear = c; load = l; en = e; d3 = d;
        @(posedge ck);
        #1;
        na = nxt_t(ma, c, l, e);
        nb = nxt_t(mb, c, l, e);
        nc = nxt_t(mc, c, l, e);
        ma = nxt_m(ma, 2, 1'b0, c, l, e, d);
        mb = nxt_m(mb, 2, 1'b1, c, l, e, d);
        mc = nxt_m(mc, 3, 1'b0, c, l, e, d);
        ta = na; tb = nb; tcm = nc;
        n_vec++;
        chk("model_qa",  {4'h0, qa}, to_bcd(ma, 2));
        chk("model_tca", {11'h0, tca}, {11'h0, ta});
        chk("model_za",  {11'h0, za}, {11'h0, ma == 0});
        chk("model_qb",  {4'h0, qb}, to_bcd(mb, 2));
        chk("model_tcb", {11'h0, tcb}, {11'h0, tb});
        chk("model_zb",  {11'h0, zb}, {11'h0, mb == 0});
        chk("model_qc",  qc, to_bcd(mc, 3));
        chk("model_tcc", {11'h0, tcc}, {11'h0, tcm});
        chk("model_zc",  {11'h0, zc}, {11'h0, mc == 0});
    endtask

    function automatic vec_t mk(logic c, logic l, logic e, logic [7:0] d,
                                logic [7:0] xa, logic xta, logic [7:0] xb, logic xtb);
        vec_t v;
        v.clr = c; v.ld = l; v.en = e; v.d = d;
        v.qa = xa; v.tca = xta; v.qb = xb; v.tcb = xtb;
        return v;
    endfunction

    initial begin
        ma = 0; mb = 0; mc = 0; ta = 0; tb = 0; tcm = 0;

        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h37, 8'h37, 0, 8'h37, 0));
        tbl.push_back(mk(1, 1, 1, 8'h37, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 8'h21, 0, 8'h21, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h20, 0, 8'h20, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h19, 0, 8'h19, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h18, 0, 8'h18, 0));
        tbl.push_back(mk(0, 1, 0, 8'h03, 8'h03, 0, 8'h03, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h02, 0, 8'h02, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h01, 0, 8'h01, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 8'h00, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 8'h99, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 8'h98, 0));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h01, 0, 8'h01, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 8'h00, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 8'h99, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 8'h98, 0));
        tbl.push_back(mk(0, 1, 0, 8'hAF, 8'h99, 0, 8'h99, 0));
        tbl.push_back(mk(0, 1, 1, 8'h50, 8'h50, 0, 8'h50, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h42, 8'h42, 0, 8'h42, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 8'h00, 8'h42, 0, 8'h42, 0));
        tbl.push_back(mk(0, 1, 0, 8'h10, 8'h10, 0, 8'h10, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h09, 0, 8'h09, 0));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h01, 0, 8'h01, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 8'h00, 1));
        tbl.push_back(mk(1, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0));

        repeat (2) @(posedge ck);
        #1;

        foreach (tbl[k]) begin
            step(tbl[k].clr, tbl[k].ld, tbl[k].en, {4'h0, tbl[k].d});
            chk("tbl_qa",  {4'h0, qa}, {4'h0, tbl[k].qa});
            chk("tbl_tca", {11'h0, tca}, {11'h0, tbl[k].tca});
            chk("tbl_za",  {11'h0, za}, {11'h0, tbl[k].qa == 8'h00});
            chk("tbl_qb",  {4'h0, qb}, {4'h0, tbl[k].qb});
            chk("tbl_tcb", {11'h0, tcb}, {11'h0, tbl[k].tcb});
        end

        // Three-digit boundaries: full borrow chain, clamp, and reaching zero from 1.
        step(0, 1, 0, 12'h100);
        chk("d3_load100", qc, 12'h100);
        step(0, 0, 1, 12'h000);
        chk("d3_borrow", qc, 12'h099);
        chk("d3_tc_borrow", {11'h0, tcc}, 12'h000);
        step(0, 1, 0, 12'hFAF);
        chk("d3_clamp", qc, 12'h999);
        step(0, 1, 0, 12'h001);
        step(0, 0, 1, 12'h000);
        chk("d3_zero", qc, 12'h000);
        chk("d3_tc", {11'h0, tcc}, 12'h001);
        step(0, 0, 1, 12'h000);
        chk("d3_hold0", qc, 12'h000);
        chk("d3_tc_drop", {11'h0, tcc}, 12'h000);

        for (int k = 0; k < 400; k++) begin
            logic        c, l, e;
            logic [11:0] d;
            c = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) d = 12'($urandom_range(0, 5));
            else d = 12'($urandom);
            step(c, l, e, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_cnt_s.md
# bcd_down_cnt_s

Synchronous multi-digit BCD down-counter. It is the counting-down counterpart of the team's ripple BCD up-counter, used for countdown timers and presettable delays. All flops share one clock. The block supports parallel preset load, count enable, an optional wrap-around mode, a zero flag and a one-cycle terminal-count pulse.

## Interface
- DIGITS, 2, number of BCD digits (1–4); digit 0 is least significant.
- WRAP, 0, 0 = stop at zero; 1 = wrap from all-zero to all-nine.

- CK  input  1  clock; all state updates on posedge CK.
- Clear  input  1  reset; synchronous, active-high.
- Load  input  1  preset strobe, sampled at posedge CK.
- En  input  1  count enable, sampled at posedge CK.
- D  input  4*DIGITS  preset value, BCD, digit i at D[4i+3:4i].
- Q  output  4*DIGITS  registered count, BCD.
- Zero  output  1  combinational, high when Q is all zero.
- Tc  output  1  registered terminal-count pulse.

## Operation
Priority per edge: Clear > Load > En > hold.

- **Clear=1**
  - Q ← 0, Tc ← 0.
  - Load, En and D are ignored.
- **Load=1 (Clear=0)**
  - Each digit of D is copied to Q.
  - Any digit greater than 9 (A–F) is clamped to 9; other digits are unaffected.
  - Tc ← 0, including when the loaded value is zero.
  - En is ignored in the same cycle.
- **En=1, Q≠0 (no Clear, no Load)**
  - BCD decrement by 1.
  - Digit 0 goes from d to d−1. If digit 0 is 0, it becomes 9 and borrows from digit 1; the borrow ripples through successive zero digits in the same cycle.
  - No intermediate values appear on Q.
  - Tc ← 1 iff the new Q is all zero; otherwise Tc ← 0.
- **En=1, Q=0**
  - WRAP=0: Q holds at 0, Tc ← 0.
  - WRAP=1: Q ← all digits 9, Tc ← 0.
- **En=0 (no Clear, no Load)**
  - Q holds, Tc ← 0.
- Q never holds a non-BCD digit after any operation.
- Zero = (Q == 0); it is purely a decode of Q.
- Tc is high for exactly one cycle per decrement that reaches zero. It stays high only if that same transition recurs, which cannot happen back-to-back.

## Timing
- Reset values, one edge after Clear=1: Q=0, Zero=1, Tc=0.
- Before the first Clear, outputs are undefined. The bench must apply Clear first.
- Load → Q latency: 1 edge.
- En → Q latency: 1 edge.
- Tc asserts on the same edge that Q becomes 0 via decrement, and deasserts on the next edge.
- Zero follows Q combinationally, with zero additional latency.
- Clear asserted during counting takes effect on the next edge. Any pending Tc is forced to 0 on that edge.
- Load and En both high: Load wins and no decrement occurs in that cycle.
- Full borrow chain (e.g. 100 → 099 with DIGITS=3) completes in one edge.
- Maximum count with DIGITS=n is 10^n − 1. No binary arithmetic is ever exposed on Q.

## Test plan
All scenarios use DIGITS=2 unless stated.
- **Reset:** Load D=8'h37, then Clear=1 with Load=1, En=1 → next edge Q=8'h00, Zero=1, Tc=0.
- **Borrow across digits:** Load D=8'h21, then En=1 for 3 edges → Q=8'h20, 8'h19, 8'h18; Tc=0 throughout.
- **Terminal count, WRAP=0:** Load 8'h03, En=1 held → Q=02, 01, 00.
  - Tc=1 only on the edge where Q=00.
  - Further edges keep Q=00, Tc=0, Zero=1.
- **Wrap, WRAP=1:** Load 8'h01, En=1 held → Q=00 with Tc=1, then Q=99 with Tc=0, then 98.
- **Clamp and priority:**
  - Load D=8'hAF → Q=8'h99.
  - Load=1 with En=1 and D=8'h50 → Q=8'h50, not 49.
  - Load D=8'h00 → Q=00, Tc=0.
- **Width and enable hold:**
  - DIGITS=3: Load 12'h100, En=1 → Q=12'h099 in one edge.
  - En=0 for 5 edges → Q unchanged, Tc=0.
